// File: rtl/dmux4x32_buf.sv
// dmux4x32_buf
// Buffered 1-to-4 word demultiplexer. A single producer presents a word on
// 'a' with a destination select 's'; the word is queued in one of four
// independent circular FIFOs, each drained by its own valid/ready consumer.
//
// Ports:
//   clk      - clock, all state updates on rising edge
//   clrn     - asynchronous active-low reset (clears pointers, counts, storage)
//   a        - input word
//   s        - destination select (0..3 -> y0..y3)
//   a_valid  - producer has a word on a/s
//   a_ready  - selected destination FIFO has room
//   y0..y3   - head word of each destination FIFO
//   y_valid  - bit i set when FIFO i is non-empty
//   y_ready  - bit i: consumer i takes yi this cycle
//   busy     - any FIFO non-empty
module dmux4x32_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [WIDTH-1:0] a,
    input  logic [1:0]       s,
    input  logic             a_valid,
    output logic             a_ready,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic [3:0]       y_valid,
    input  logic [3:0]       y_ready,
    output logic             busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q    [4][DEPTH];
    logic [WIDTH-1:0] mem_d    [4][DEPTH];
    logic [PTR_W-1:0] wr_ptr_q [4];
    logic [PTR_W-1:0] wr_ptr_d [4];
    logic [PTR_W-1:0] rd_ptr_q [4];
    logic [PTR_W-1:0] rd_ptr_d [4];
    logic [CNT_W-1:0] count_q  [4];
    logic [CNT_W-1:0] count_d  [4];

    logic             push;
    logic [3:0]       push_sel;
    logic [3:0]       pop;

    // Handshake decode. a_ready looks only at the registered count of the
    // selected FIFO, so a full FIFO being popped this cycle still refuses
    // the push; this keeps y_ready out of the a_ready path.
    always_comb begin
        a_ready  = (count_q[s] != FULL_CNT);
        push     = a_valid & a_ready;
        push_sel = push ? (4'b0001 << s) : 4'b0000;
        for (int i = 0; i < 4; i++) begin
            y_valid[i] = (count_q[i] != '0);
        end
        pop  = y_valid & y_ready;
        busy = |y_valid;
    end

    // Heads are read straight from storage at the read pointer; when a FIFO
    // is empty this shows a stale entry, which consumers ignore.
    always_comb begin
        y0 = mem_q[0][rd_ptr_q[0]];
        y1 = mem_q[1][rd_ptr_q[1]];
        y2 = mem_q[2][rd_ptr_q[2]];
        y3 = mem_q[3][rd_ptr_q[3]];
    end

    // Next-state for all four FIFOs. A simultaneous push and pop on the same
    // FIFO advances both pointers and leaves the count unchanged.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        for (int i = 0; i < 4; i++) begin
            if (push_sel[i]) begin
                mem_d[i][wr_ptr_q[i]] = a;
                wr_ptr_d[i]           = wr_ptr_q[i] + PTR_W'(1);
            end
            if (pop[i]) begin
                rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
            end
            case ({push_sel[i], pop[i]})
                2'b10:   count_d[i] = count_q[i] + CNT_W'(1);
                2'b01:   count_d[i] = count_q[i] - CNT_W'(1);
                default: count_d[i] = count_q[i];
            endcase
        end
    end

    // State registers. Reset also clears storage so every head reads zero.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < 4; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
                for (int j = 0; j < DEPTH; j++) begin
                    mem_q[i][j] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                count_q[i]  <= count_d[i];
                for (int j = 0; j < DEPTH; j++) begin
                    mem_q[i][j] <= mem_d[i][j];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmux4x32_buf.sv
// Testbench for dmux4x32_buf: directed scenarios plus a randomized stream,
// checked against per-destination word queues.
module tb_dmux4x32_buf;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        clrn;
    logic [31:0] a;
    logic [1:0]  s;
    logic        a_valid;
    logic        a_ready;
    logic [31:0] y0, y1, y2, y3;
    logic [3:0]  y_valid;
    logic [3:0]  y_ready;
    logic        busy;

    logic [31:0] mq [4][$];
    int          checks = 0;
    int          errors = 0;
    bit          last_accepted;

    dmux4x32_buf #(.WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .clrn    (clrn),
        .a       (a),
        .s       (s),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .y0      (y0),
        .y1      (y1),
        .y2      (y2),
        .y3      (y3),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .busy    (busy)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    function automatic logic [31:0] get_y(input int i);
        case (i)
            0:       return y0;
            1:       return y1;
            2:       return y2;
            default: return y3;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Compare every output against the reference queues.
    task automatic checkModel(input string tag);
        bit any;
        any = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("%s_y_valid%0d", tag, i), 32'(y_valid[i]),
                        32'(mq[i].size() > 0));
            if (mq[i].size() > 0) begin
                any = 1'b1;
                checkOutput($sformatf("%s_y%0d", tag, i), get_y(i), mq[i][0]);
            end
        end
        checkOutput($sformatf("%s_busy", tag), 32'(busy), 32'(any));
    endtask

    // One clock cycle: drive inputs, check a_ready before the edge, advance
    // the reference queues at the edge, then check the outputs after it.
    task automatic applyStimulus(input logic av, input logic [1:0] sel,
                                 input logic [3:0] yr, input logic [31:0] data);
        bit exp_ready;
        a_valid = av;
        s       = sel;
        y_ready = yr;
        a       = data;
        #1;
        exp_ready = (mq[sel].size() != DEPTH);
        checkOutput("a_ready", 32'(a_ready), 32'(exp_ready));
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            if (yr[i] && mq[i].size() > 0) begin
                void'(mq[i].pop_front());
            end
        end
        last_accepted = av && exp_ready;
        if (last_accepted) begin
            mq[sel].push_back(data);
        end
        #1;
        checkModel("step");
    endtask

    initial begin
        int          sent;
        int          cycles;
        int          total;
        bit          pend;
        logic        av;
        logic [1:0]  ps;
        logic [31:0] pd;

        clrn    = 1'b0;
        a_valid = 1'b0;
        s       = 2'd0;
        a       = '0;
        y_ready = 4'b0000;
        #2;
        checkOutput("rst_y_valid", 32'(y_valid), 32'h0);
        checkOutput("rst_a_ready", 32'(a_ready), 32'h1);
        checkOutput("rst_busy",    32'(busy),    32'h0);
        checkOutput("rst_y0", y0, 32'h0);
        checkOutput("rst_y3", y3, 32'h0);
        #5;
        clrn = 1'b1;
        $display("[TB] reset released");

        // Single route to y2, first push right after reset release.
        applyStimulus(1'b1, 2'b10, 4'b0000, 32'hDEADBEEF);
        checkOutput("route_y_valid", 32'(y_valid), 32'h4);
        checkOutput("route_y2", y2, 32'hDEADBEEF);
        applyStimulus(1'b0, 2'b10, 4'b0100, 32'h0);
        checkOutput("route_pop_y_valid", 32'(y_valid), 32'h0);

        // Backpressure on FIFO1: two words fill it, the third is held.
        applyStimulus(1'b1, 2'b01, 4'b0000, 32'h1);
        applyStimulus(1'b1, 2'b01, 4'b0000, 32'h2);
        s = 2'b00;
        #1;
        checkOutput("bp_ready_s0", 32'(a_ready), 32'h1);
        s = 2'b01;
        #1;
        checkOutput("bp_ready_s1", 32'(a_ready), 32'h0);
        applyStimulus(1'b1, 2'b01, 4'b0000, 32'h3);
        applyStimulus(1'b1, 2'b01, 4'b0010, 32'h3);
        checkOutput("bp_head_after_pop", y1, 32'h2);
        applyStimulus(1'b1, 2'b01, 4'b0000, 32'h3);
        applyStimulus(1'b0, 2'b01, 4'b0010, 32'h0);
        checkOutput("bp_head_third", y1, 32'h3);
        applyStimulus(1'b0, 2'b01, 4'b0010, 32'h0);

        // Full FIFO3 popped while a push is offered: push refused that cycle.
        applyStimulus(1'b1, 2'b11, 4'b0000, 32'hA0);
        applyStimulus(1'b1, 2'b11, 4'b0000, 32'hA1);
        applyStimulus(1'b1, 2'b11, 4'b1000, 32'hA2);
        checkOutput("fullpop_y3", y3, 32'hA1);
        applyStimulus(1'b1, 2'b11, 4'b0000, 32'hA2);
        applyStimulus(1'b0, 2'b11, 4'b1000, 32'h0);
        checkOutput("fullpop_next", y3, 32'hA2);
        applyStimulus(1'b0, 2'b11, 4'b1000, 32'h0);

        // Concurrent pops on all four FIFOs plus a push to FIFO0.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 2'(i), 4'b0000, 32'hC0 + 32'(i));
        end
        applyStimulus(1'b1, 2'b00, 4'b1111, 32'hC5);
        checkOutput("conc_y_valid", 32'(y_valid), 32'h1);
        checkOutput("conc_y0", y0, 32'hC5);
        applyStimulus(1'b0, 2'b00, 4'b0001, 32'h0);

        // Randomized stream with gaps, random pops and held stalls.
        sent   = 0;
        cycles = 0;
        pend   = 1'b0;
        ps     = 2'd0;
        pd     = '0;
        while (sent < 100 && cycles < 3000) begin
            if (!pend) begin
                ps = 2'($urandom_range(0, 3));
                pd = $urandom;
                av = ($urandom_range(0, 3) != 0);
            end else begin
                av = 1'b1;
            end
            applyStimulus(av, ps, 4'($urandom), pd);
            if (last_accepted) sent++;
            pend = av && !last_accepted;
            cycles++;
        end
        checkOutput("stream_sent", 32'(sent), 32'd100);
        cycles = 0;
        while (busy && cycles < 50) begin
            applyStimulus(1'b0, 2'b00, 4'b1111, 32'h0);
            cycles++;
        end
        total = 0;
        for (int i = 0; i < 4; i++) total += mq[i].size();
        checkOutput("drain_model_empty", 32'(total), 32'h0);
        checkOutput("drain_busy", 32'(busy), 32'h0);

        // Asynchronous reset with FIFO1 holding two words.
        applyStimulus(1'b1, 2'b01, 4'b0000, 32'h11);
        applyStimulus(1'b1, 2'b01, 4'b0000, 32'h22);
        a_valid = 1'b0;
        s       = 2'b01;
        #2;
        clrn = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) mq[i].delete();
        checkOutput("arst_y_valid", 32'(y_valid), 32'h0);
        checkOutput("arst_a_ready", 32'(a_ready), 32'h1);
        checkOutput("arst_busy",    32'(busy),    32'h0);
        checkOutput("arst_y1", y1, 32'h0);
        checkOutput("arst_y2", y2, 32'h0);
        #1;
        clrn = 1'b1;
        applyStimulus(1'b0, 2'b01, 4'b1111, 32'h0);
        applyStimulus(1'b0, 2'b01, 4'b1111, 32'h0);
        checkOutput("arst_after_y_valid", 32'(y_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmux4x32_buf.md
# dmux4x32_buf

Buffered 1-to-4 demultiplexer for 32-bit words: the distribution counterpart of the 4-to-1 word selector in the datapath. An upstream producer presents a word together with a 2-bit destination select, and the block steers the word into one of four per-destination FIFOs. Each destination drains its FIFO independently through a valid/ready handshake. It sits between a single result/writeback source and four consumers, such as register-file ports or unit queues, that may stall independently.

## Interface
- WIDTH, 32, data word width
- DEPTH, 2, entries per destination FIFO; power of two, ≥2
- clk  input  1  clock; all state updates on rising edge
- clrn  input  1  asynchronous active-low reset
- a  input  WIDTH  input word
- s  input  2  destination select: 00→y0, 01→y1, 10→y2, 11→y3
- a_valid  input  1  producer has a word on a/s
- a_ready  output  1  selected destination can accept this cycle
- y0, y1, y2, y3  output  WIDTH  head word of each destination FIFO
- y_valid  output  4  bit i: FIFO i non-empty, yi valid
- y_ready  input  4  bit i: consumer i takes yi this cycle
- busy  output  1  OR of y_valid

## Operation
- Four independent circular FIFOs, each DEPTH deep. Each FIFO has a write pointer, a read pointer, and an occupancy counter of width log2(DEPTH)+1.
- Push: a_valid & a_ready at a rising edge writes a into FIFO[s]. The write pointer of FIFO[s] increments modulo DEPTH.
- a_ready = (count[s] != DEPTH).
  - It is purely a function of s and the registered counts.
  - It does not depend on a_valid, and it has no combinational path from y_ready.
- Pop i: y_valid[i] & y_ready[i] at a rising edge advances read pointer i modulo DEPTH.
  - y_ready[i] while y_valid[i]=0 has no effect.
- Count update per FIFO:
  - +1 on push only
  - −1 on pop only
  - unchanged on simultaneous push and pop to the same FIFO (both pointers advance)
- A full FIFO does not accept a push in a cycle where it is being popped, because a_ready is already 0. No overflow is possible.
- Pops on all four outputs and one push may occur in the same cycle.
- yi is driven from the read-pointer entry of FIFO i.
  - It holds while y_valid[i]=1 and y_ready[i]=0.
  - When the FIFO is empty, yi shows the stale entry; consumers ignore it.
- Ordering is preserved per destination only. No ordering guarantee exists across destinations.
- a_valid=1 with a_ready=0 is a stall. The producer holds a/s stable; the block does not latch anything.
- Reset (clrn=0, asynchronous):
  - all pointers and counts go to 0
  - storage is cleared to 0, so y0..y3 = 0
  - y_valid = 0000, busy = 0, a_ready = 1
  - A reset mid-operation discards all buffered words, and state takes effect immediately without waiting for clk.
- Release of clrn: the first push can be accepted at the first rising edge after release.

## Timing
- Latency: a word accepted at edge N shows y_valid[s]=1 and yi=word after edge N, so it is poppable at edge N+1.
- Throughput: one push per cycle sustained to any destination whose consumer pops every cycle. This is sustained at DEPTH≥2 with no bubbles.
- a_ready changes only after a clock edge, or combinationally when s changes.
- y_valid, yi and busy are registered-state functions with no input-to-output combinational paths.

## Test plan
- Reset check: assert clrn=0 mid-stream with FIFO1 holding 2 words → y_valid=0000, y0..y3=0, a_ready=1 immediately without a clock edge; the words are not emitted after release.
- Single route: push 0xDEADBEEF with s=10 and y_ready=0000 → after the edge, y_valid=0100 and y2=0xDEADBEEF; pop with y_ready=0100 → y_valid=0000.
- Full/backpressure: with y_ready=0, push 0x1, 0x2 to s=01 → a_ready=0 while s=01 and a_ready=1 for s=00; a third push is held, then accepted one edge after the first pop; the output order is 0x1, 0x2, 0x3.
- Full with simultaneous pop: FIFO3 full, y_ready[3]=1, a_valid=1, s=11 → no push that cycle (a_ready=0); count goes to 1; the push is accepted next cycle.
- Streaming: 100 random words with random s, random y_ready, and random a_valid gaps → each yi sequence equals the scoreboard of words sent with that s, in order, with no loss or duplication.
- Concurrent pops: all four FIFOs non-empty, y_ready=1111 plus a push to s=00 → all four counts update correctly, FIFO0 count unchanged, busy tracks the OR of y_valid.
